// File: rtl/mac_pipe.sv
// mac_pipe: three-stage pipelined signed multiply-accumulate with sticky overflow
// and selectable wrap or saturate arithmetic.
module mac_pipe #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 20,
    parameter bit SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  a,
    input  logic [IN_W-1:0]  b,
    input  logic             valid_in,
    input  logic             clear_in,
    output logic [ACC_W-1:0] f,
    output logic             valid_out,
    output logic             overflow
);
    localparam int PW = 2 * IN_W;
    logic              v1_q, c1_q, v2_q, c2_q, v3_q, ovf_q, ovf_d;
    logic [IN_W-1:0]   a_q, b_q;
    logic [PW-1:0]     p_q, p_d;
    logic [ACC_W-1:0]  f_q, f_d;
    logic [ACC_W:0]    p_ext, s;
    logic              s_ovf;
    assign p_d   = $signed({{IN_W{a_q[IN_W-1]}}, a_q}) * $signed({{IN_W{b_q[IN_W-1]}}, b_q});
    assign p_ext = {{(ACC_W + 1 - PW){p_q[PW-1]}}, p_q};
    assign s     = {f_q[ACC_W-1], f_q} + p_ext;
    // The sum is one bit wider than f; it fits only if its top two bits agree.
    assign s_ovf = s[ACC_W] ^ s[ACC_W-1];
    // Rail value: sign bit of s followed by its complement gives max for s>0, min for s<0.
    assign f_d   = c2_q ? p_ext[ACC_W-1:0]
                 : (s_ovf && SAT) ? {s[ACC_W], {(ACC_W - 1){~s[ACC_W]}}}
                 : s[ACC_W-1:0];
    assign ovf_d = !c2_q && (ovf_q || s_ovf);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1_q  <= 1'b0;
            c1_q  <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            v2_q  <= 1'b0;
            c2_q  <= 1'b0;
            p_q   <= '0;
            v3_q  <= 1'b0;
            f_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            v1_q <= valid_in;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (valid_in) begin
                a_q  <= a;
                b_q  <= b;
                c1_q <= clear_in;
            end
            if (v1_q) begin
                p_q  <= p_d;
                c2_q <= c1_q;
            end
            if (v2_q) begin
                f_q   <= f_d;
                ovf_q <= ovf_d;
            end
        end
    end
    assign f         = f_q;
    assign valid_out = v3_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_mac_pipe.sv
// tb_mac_pipe: drives a wrapping and a saturating mac_pipe with shared stimulus and
// checks both against directed constants and a sample-level reference model.
module tb_mac_pipe;
    localparam int  ACC_W = 20;
    localparam longint HI = (64'sd1 <<< (ACC_W - 1)) - 1;
    localparam longint LO = -(64'sd1 <<< (ACC_W - 1));
    logic clk = 1'b0, reset = 1'b0, valid_in = 1'b0, clear_in = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic [ACC_W-1:0] f0, f1;
    logic vo0, vo1, ov0, ov1;
    int sf0, sf1;
    int n_cmp = 0, n_err = 0;
    typedef struct { bit v; bit c; longint p; } smp_t;
    smp_t pipe[$];
    longint mf[2];
    bit mo[2];
    bit mv;
    assign sf0 = int'($signed(f0));
    assign sf1 = int'($signed(f1));

    mac_pipe #(.IN_W(8), .ACC_W(ACC_W), .SAT(1'b0)) dut_wrap (
        .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in), .clear_in(clear_in),
        .f(f0), .valid_out(vo0), .overflow(ov0));
    mac_pipe #(.IN_W(8), .ACC_W(ACC_W), .SAT(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in), .clear_in(clear_in),
        .f(f1), .valid_out(vo1), .overflow(ov1));

    always #5 clk = ~clk;

    task automatic model_reset();
        pipe.delete();
        mf = '{0, 0};
        mo = '{0, 0};
        mv = 1'b0;
    endtask

    // A sample seen at edge E lands in f at E+2: keep the last two samples in flight.
    task automatic model_edge();
        smp_t e;
        longint sm;
        if (!reset) begin
            model_reset();
            return;
        end
        mv = 1'b0;
        if (pipe.size() == 2) begin
            e = pipe.pop_front();
            mv = e.v;
            for (int s = 0; s < 2; s++) begin
                if (e.v && e.c) begin
                    mf[s] = e.p;
                    mo[s] = 1'b0;
                end else if (e.v) begin
                    sm = mf[s] + e.p;
                    if (sm > HI || sm < LO) begin
                        mo[s] = 1'b1;
                        mf[s] = (s == 1) ? ((sm > 0) ? HI : LO) : ((sm > HI) ? sm - 2 * (HI + 1) : sm + 2 * (HI + 1));
                    end else mf[s] = sm;
                end
            end
        end
        e.v = valid_in;
        e.c = clear_in;
        e.p = longint'($signed(a)) * longint'($signed(b));
        pipe.push_back(e);
    endtask

    task automatic cyc(input logic r, input logic v, input logic c, input logic [7:0] aa, input logic [7:0] bb);
        @(negedge clk);
        reset = r; valid_in = v; clear_in = c; a = aa; b = bb;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 8'd5, 8'd5);
        n_cmp++; if (sf0 !== 0) begin n_err++; $display("FAIL reset_f0: got %0d want 0", sf0); end
        n_cmp++; if (sf1 !== 0) begin n_err++; $display("FAIL reset_f1: got %0d want 0", sf1); end
        n_cmp++; if ({vo0, vo1} !== 2'b00) begin n_err++; $display("FAIL reset_vo: got %b want 00", {vo0, vo1}); end
        n_cmp++; if ({ov0, ov1} !== 2'b00) begin n_err++; $display("FAIL reset_ovf: got %b want 00", {ov0, ov1}); end
    endtask

    task automatic test_basic();
        cyc(1'b1, 1'b1, 1'b1, 8'd3, 8'd4);
        cyc(1'b1, 1'b1, 1'b0, 8'hFB, 8'd6);
        cyc(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
        n_cmp++; if (vo0 !== 1'b1 || sf0 !== 12) begin n_err++; $display("FAIL basic_first: got vo=%b f=%0d want vo=1 f=12", vo0, sf0); end
        cyc(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
        n_cmp++; if (vo0 !== 1'b1 || sf0 !== -18) begin n_err++; $display("FAIL basic_second: got vo=%b f=%0d want vo=1 f=-18", vo0, sf0); end
        n_cmp++; if (sf1 !== -18 || ov0 !== 1'b0) begin n_err++; $display("FAIL basic_sat_inst: got f=%0d ovf=%b want f=-18 ovf=0", sf1, ov0); end
        cyc(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
        n_cmp++; if (vo0 !== 1'b0 || sf0 !== -18) begin n_err++; $display("FAIL basic_idle: got vo=%b f=%0d want vo=0 f=-18", vo0, sf0); end
    endtask

    task automatic test_overflow();
        logic v, c;
        logic [7:0] aa, bb;
        int k;
        for (int i = 0; i < 37; i++) begin
            v = 1'b1; c = 1'b0; aa = 8'h80; bb = 8'h80;
            if (i == 0) c = 1'b1;
            if (i == 33) begin aa = 8'hFF; bb = 8'd1; end
            if (i == 34) begin aa = 8'd2; bb = 8'd2; c = 1'b1; end
            if (i >= 35) v = 1'b0;
            cyc(1'b1, v, c, aa, bb);
            k = i - 1;
            if (k >= 1 && k <= 31) begin
                n_cmp++; if (sf0 !== 16384 * k || ov0 !== 1'b0) begin n_err++; $display("FAIL wrap_ramp%0d: got f=%0d ovf=%b want f=%0d ovf=0", k, sf0, ov0, 16384 * k); end
                n_cmp++; if (sf1 !== 16384 * k || ov1 !== 1'b0) begin n_err++; $display("FAIL sat_ramp%0d: got f=%0d ovf=%b want f=%0d ovf=0", k, sf1, ov1, 16384 * k); end
            end
            if (k == 32) begin
                n_cmp++; if (sf0 !== -524288 || ov0 !== 1'b1) begin n_err++; $display("FAIL wrap_32: got f=%0d ovf=%b want f=-524288 ovf=1", sf0, ov0); end
                n_cmp++; if (sf1 !== 524287 || ov1 !== 1'b1) begin n_err++; $display("FAIL sat_32: got f=%0d ovf=%b want f=524287 ovf=1", sf1, ov1); end
            end
            if (k == 33) begin
                n_cmp++; if (sf0 !== -507904 || ov0 !== 1'b1) begin n_err++; $display("FAIL wrap_33: got f=%0d ovf=%b want f=-507904 ovf=1", sf0, ov0); end
                n_cmp++; if (sf1 !== 524287 || ov1 !== 1'b1) begin n_err++; $display("FAIL sat_33: got f=%0d ovf=%b want f=524287 ovf=1", sf1, ov1); end
            end
            if (k == 34) begin
                n_cmp++; if (sf0 !== -507905 || ov0 !== 1'b1) begin n_err++; $display("FAIL wrap_neg: got f=%0d ovf=%b want f=-507905 ovf=1", sf0, ov0); end
                n_cmp++; if (sf1 !== 524286 || ov1 !== 1'b1) begin n_err++; $display("FAIL sat_off_rail: got f=%0d ovf=%b want f=524286 ovf=1", sf1, ov1); end
            end
            if (k == 35) begin
                n_cmp++; if (sf0 !== 4 || ov0 !== 1'b0 || vo0 !== 1'b1) begin n_err++; $display("FAIL wrap_clear: got f=%0d ovf=%b vo=%b want f=4 ovf=0 vo=1", sf0, ov0, vo0); end
                n_cmp++; if (sf1 !== 4 || ov1 !== 1'b0 || vo1 !== 1'b1) begin n_err++; $display("FAIL sat_clear: got f=%0d ovf=%b vo=%b want f=4 ovf=0 vo=1", sf1, ov1, vo1); end
            end
            if (k == 36) begin
                n_cmp++; if ({vo0, vo1} !== 2'b00 || sf0 !== 4) begin n_err++; $display("FAIL clear_pulse: got vo=%b f=%0d want vo=00 f=4", {vo0, vo1}, sf0); end
            end
        end
    endtask

    task automatic test_reset_mid();
        cyc(1'b1, 1'b1, 1'b0, 8'd7, 8'd9);
        cyc(1'b1, 1'b1, 1'b0, 8'hFD, 8'd5);
        n_cmp++; if (sf0 !== 4) begin n_err++; $display("FAIL mid_pre: got f=%0d want 4", sf0); end
        reset = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (sf0 !== 0 || sf1 !== 0) begin n_err++; $display("FAIL mid_async_f: got %0d/%0d want 0/0", sf0, sf1); end
        n_cmp++; if ({vo0, vo1, ov0, ov1} !== 4'b0000) begin n_err++; $display("FAIL mid_async_flags: got %b want 0000", {vo0, vo1, ov0, ov1}); end
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
            n_cmp++; if (vo0 !== 1'b0 || sf0 !== 0) begin n_err++; $display("FAIL mid_held%0d: got vo=%b f=%0d want vo=0 f=0", i, vo0, sf0); end
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
            n_cmp++; if ({vo0, vo1} !== 2'b00 || sf0 !== 0) begin n_err++; $display("FAIL mid_discard%0d: got vo=%b f=%0d want vo=00 f=0", i, {vo0, vo1}, sf0); end
        end
    endtask

    task automatic test_random();
        logic v, c;
        logic [7:0] aa, bb;
        for (int i = 0; i < 1000; i++) begin
            v = ($urandom_range(3, 0) != 0);
            c = ($urandom_range(63, 0) == 0);
            aa = 8'($urandom);
            case ($urandom_range(2, 0))
                0: bb = aa;
                1: bb = -aa;
                default: bb = 8'($urandom);
            endcase
            cyc(1'b1, v, c, aa, bb);
            n_cmp++; if ({vo0, vo1} !== {mv, mv}) begin n_err++; $display("FAIL rnd_vo@%0d: got %b want %b%b", i, {vo0, vo1}, mv, mv); end
            n_cmp++; if (longint'(sf0) !== mf[0] || ov0 !== mo[0]) begin n_err++; $display("FAIL rnd_wrap@%0d: got f=%0d ovf=%b want f=%0d ovf=%b", i, sf0, ov0, mf[0], mo[0]); end
            n_cmp++; if (longint'(sf1) !== mf[1] || ov1 !== mo[1]) begin n_err++; $display("FAIL rnd_sat@%0d: got f=%0d ovf=%b want f=%0d ovf=%b", i, sf1, ov1, mf[1], mo[1]); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mac_pipe.md
# mac_pipe

Parametrised, pipelined signed multiply-accumulate unit. It is the next generation of the single-operand sum-of-squares accumulator, and adds:
- two independent operands;
- configurable operand and accumulator widths;
- a per-sample accumulator restart;
- a sticky overflow flag;
- selectable wrap or saturate arithmetic.

It sits between a sample source driving a valid_in strobe and a consumer that samples f on valid_out.

## Interface
- IN_W, default 8: operand width, signed two's complement; must be ≥ 2.
- ACC_W, default 20: accumulator/output width, signed; must be ≥ 2*IN_W.
- SAT, default 0: 0 = wrap on overflow; 1 = saturate on overflow.
- clk  input  1  single clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low; state is cleared while reset == 0.
- a  input  IN_W  operand A, signed.
- b  input  IN_W  operand B, signed.
- valid_in  input  1  a/b/clear_in carry a sample this cycle.
- clear_in  input  1  sample restarts the accumulation; ignored when valid_in == 0.
- f  output  ACC_W  accumulator value, signed.
- valid_out  output  1  f was updated by a sample at the preceding edge.
- overflow  output  1  sticky; an overflow has occurred since the last clear sample or reset.

## Operation
- Three registered stages, each carrying its own valid bit:
  - S1 captures a, b, clear_in.
  - S2 holds the product p = a*b as a signed 2*IN_W value, plus clear.
  - S3 is the accumulator f and the overflow flag.
- Stage data registers load only when their incoming valid is 1; otherwise they hold. Stage valid bits load every edge.
- Accumulate step, when S2 is valid:
  - Clear sample: f = sign-extended p; overflow = 0. A product cannot overflow because ACC_W ≥ 2*IN_W.
  - Non-clear sample: compute s = f + sext(p) at ACC_W+1 bits. Overflow exists if s is outside [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - No overflow: f = s.
  - Overflow with SAT=0: f = s[ACC_W-1:0] (wraps); overflow = 1.
  - Overflow with SAT=1: f = 2^(ACC_W-1)-1 if s > 0, else -2^(ACC_W-1); overflow = 1.
  - overflow, once set, stays 1 until a clear sample reaches S3 or reset is asserted.
- No sample in S2: f and overflow hold.
- valid_out equals the S3 valid bit, i.e. it is high for exactly one cycle per sample.
- After reset the accumulator is 0, so a first sample without clear_in accumulates onto 0.
- No backpressure: a new sample may be accepted every cycle, indefinitely.

## Timing
- Reset values: f = 0, valid_out = 0, overflow = 0. All stage registers and valid bits are 0.
- Reset assertion takes effect immediately (asynchronous), including mid-stream. In-flight samples are discarded and never produce valid_out.
- After reset deasserts, the first edge with valid_in = 1 is the first accepted sample.
- Latency, for a sample presented with valid_in = 1 at edge E:
  - S1 loads at E;
  - S2 loads at E+1;
  - f updates at E+2;
  - valid_out is 1 from E+2 until E+3.
- Back-to-back samples at E, E+1, ... give f updates at E+2, E+3, ... with valid_out continuously 1.
- An idle cycle (valid_in = 0) at edge E gives valid_out = 0 after E+2, and f is unchanged.
- A clear sample following a non-clear sample on the next edge:
  - the non-clear sample updates f at its own edge;
  - the clear sample replaces f on the following edge.
  - The two samples never merge.
- Saturated f (SAT=1) stays at the rail while further same-sign samples arrive. An opposite-sign sample moves f off the rail normally.

## Test plan
Default parameters unless stated (IN_W=8, ACC_W=20). Max f = 524287; min f = -524288.
- Basic accumulate and idle hold:
  - Stimulus: after reset release, a=3 b=4 clear=1 at E; a=-5 b=6 clear=0 at E+1; valid_in=0 for E+2..E+4.
  - Response: valid_out=1 with f=12 after E+2; f=-18 after E+3; valid_out=0 after E+4; f holds -18.
- Wrap overflow (SAT=0):
  - Stimulus: 32 back-to-back samples a=-128 b=-128, first with clear=1.
  - Response: f = 16384*k after sample k up to k=31 (507904), overflow=0. After sample 32: f=-524288, overflow=1.
- Saturation (SAT=1):
  - Stimulus: same 32 samples, then a 33rd identical sample, then a=-1 b=1.
  - Response: f=524287 with overflow=1 after samples 32 and 33; then f=524286 with overflow still 1.
- Clear after overflow:
  - Stimulus: following the wrap case, a=2 b=2 clear=1.
  - Response: f=4, overflow=0, valid_out=1 for one cycle.
- Reset mid-stream:
  - Stimulus: samples at E and E+1, then reset=0 between E+1 and E+2, released after E+3.
  - Response: immediately f=0, valid_out=0, overflow=0; no valid_out pulse for the discarded samples.
- Randomised continuous stream:
  - Stimulus: 1000 cycles of random a, b, valid_in, clear_in under both SAT values.
  - Response: f, valid_out and overflow match a cycle-accurate reference model on every edge.
